// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared FSM encoding, parity selectors and parity helper for
//                the UART transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest byte the parity helper accepts; narrower data is zero-padded.
    localparam int c_parity_max_w = 64;

    function automatic logic parity_bit(input logic [c_parity_max_w-1:0] data,
                                        input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker: first set request at or
//                above rr_ptr, wrapping back to index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] pick,
    output logic          any_req
);

    logic [PW:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        pick    = '0;
        any_req = |req;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_ptr} + (PW + 1)'(k);
            if (w_sum >= (PW + 1)'(N)) begin
                w_sum = w_sum - (PW + 1)'(N);
            end
            if (req[w_sum[PW-1:0]]) begin
                pick = w_sum[PW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin sharing of one UART transmitter among N_REQ byte
//                producers; optional same-requester bursts under the macro
//                UART_TX_SCHED_BURST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
    parameter  int N_REQ      = 4,
    parameter  int FIFO_WIDTH = 8,
    parameter  bit PARITY_ODD = 1'b0,
    parameter  int TIMEOUT    = 32,
    parameter  int MAX_BURST  = 4,
    localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        Tx_clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]       tx_din,
    output logic                        tx_parity,
    output logic                        tx_start,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [GW-1:0]               grant_id,
    output logic                        timeout_err
);

    import uart_pkg::*;

    localparam int   c_tw         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic c_parity_sel = PARITY_ODD ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;

    if (N_REQ < 2 || N_REQ > 8 || FIFO_WIDTH < 1 || FIFO_WIDTH > c_parity_max_w ||
        TIMEOUT < 2 || MAX_BURST < 1) begin : g_param_check
        $error("uart_tx_scheduler: parameter out of range");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [GW-1:0]           r_rr_ptr;
    logic [c_tw-1:0]         r_tmo_cnt;
    logic [FIFO_WIDTH-1:0]   r_din;
    logic                    r_parity;
    logic [GW-1:0]           r_grant;
    logic                    r_tmo_err;

    logic [GW-1:0]           w_arb_pick;
    logic                    w_any_req;
    logic                    w_burst_take;
    logic                    w_accept;
    logic [GW-1:0]           w_sel;
    logic [GW-1:0]           w_ptr_nxt;
    logic [FIFO_WIDTH-1:0]   w_slice;
    logic [c_parity_max_w-1:0] w_par_vec;
    logic                    w_parity;
    logic                    w_tmo_hit;
    logic                    w_tmo_fire;

    rr_arbiter #(
        .N       (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (r_rr_ptr),
        .pick    (w_arb_pick),
        .any_req (w_any_req)
    );

`ifdef UART_TX_SCHED_BURST_EN
    localparam int c_bw = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [c_bw-1:0] r_burst_cnt;
    logic            r_burst_pending;

    // A burst continuation is only offered in the first IDLE cycle after tx_done.
    assign w_burst_take = (r_state == IDLE) && r_burst_pending && req_valid[r_grant];

    always_ff @(posedge Tx_clk) begin
        if (rst) begin
            r_burst_cnt     <= '0;
            r_burst_pending <= 1'b0;
        end else begin
            if (r_state == WAIT_DONE && tx_done) begin
                r_burst_pending <= req_valid[r_grant] &&
                                   (r_burst_cnt < c_bw'(MAX_BURST - 1));
            end else if (r_state == IDLE) begin
                r_burst_pending <= 1'b0;
            end
            if (w_accept) begin
                r_burst_cnt <= w_burst_take ? (r_burst_cnt + 1'b1) : '0;
            end
        end
    end
`else
    assign w_burst_take = 1'b0;
`endif

    assign w_accept  = (r_state == IDLE) && (w_burst_take || w_any_req);
    assign w_sel     = w_burst_take ? r_grant : w_arb_pick;
    assign w_ptr_nxt = (w_arb_pick == GW'(N_REQ - 1)) ? '0 : (w_arb_pick + 1'b1);
    assign w_tmo_hit = (r_tmo_cnt == c_tw'(TIMEOUT - 1));

    always_comb begin
        w_slice   = '0;
        w_par_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == GW'(i)) begin
                w_slice = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
        w_par_vec[FIFO_WIDTH-1:0] = w_slice;
    end

    assign w_parity = parity_bit(w_par_vec, c_parity_sel);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    // tx_done takes priority over an expiring timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = IDLE;
                    w_tmo_fire  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Tx_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_tmo_cnt <= '0;
            r_din     <= '0;
            r_parity  <= 1'b0;
            r_grant   <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_err <= w_tmo_fire;
            if (w_accept) begin
                r_din    <= w_slice;
                r_parity <= w_parity;
                r_grant  <= w_sel;
                if (!w_burst_take) begin
                    r_rr_ptr <= w_ptr_nxt;
                end
            end
            if (r_state == LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT_DONE && !tx_done && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign tx_din      = r_din;
    assign tx_parity   = r_parity;
    assign grant_id    = r_grant;
    assign timeout_err = r_tmo_err;
    assign tx_start    = (r_state == LAUNCH);
    assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Directed vector table plus multi-cycle sequences for the
//                UART transmit scheduler (even and odd parity instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    logic        Tx_clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        tx_done;

    logic [3:0]  req_ready;
    logic [7:0]  tx_din;
    logic        tx_parity;
    logic        tx_start;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    logic [3:0]  o_req_ready;
    logic [7:0]  o_tx_din;
    logic        o_tx_parity;
    logic        o_tx_start;
    logic        o_busy;
    logic [1:0]  o_grant_id;
    logic        o_timeout_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 Tx_clk = ~Tx_clk;

    uart_tx_scheduler #(
        .N_REQ(4), .FIFO_WIDTH(8), .PARITY_ODD(1'b0), .TIMEOUT(32), .MAX_BURST(4)
    ) dut (
        .Tx_clk(Tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_din(tx_din), .tx_parity(tx_parity),
        .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_scheduler #(
        .N_REQ(4), .FIFO_WIDTH(8), .PARITY_ODD(1'b1), .TIMEOUT(32), .MAX_BURST(4)
    ) dut_odd (
        .Tx_clk(Tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(o_req_ready), .tx_din(o_tx_din), .tx_parity(o_tx_parity),
        .tx_start(o_tx_start), .tx_done(tx_done), .busy(o_busy),
        .grant_id(o_grant_id), .timeout_err(o_timeout_err)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        done;
        logic [3:0]  ready;
        logic        start;
        logic        busy;
        logic [7:0]  din;
        logic        par;
        logic        podd;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs[17];
    int   exp_rr[5];
    int   exp_b[8];

    task automatic tick();
        @(posedge Tx_clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        tx_done   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input string name, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s: tx_start not seen within 40 cycles", name);
        end
    endtask

    // Wait for a launch, hold the frame for f cycles, then pulse tx_done.
    task automatic run_frame(input int f, input string name,
                             output logic [1:0] gid, output logic [7:0] din, output int scyc);
        bit seen;
        wait_start(name, seen);
        gid  = grant_id;
        din  = tx_din;
        scyc = cyc;
        repeat (f) tick();
        tx_done = 1'b1;
        #1;
        chk({name, "_din_hold"}, tx_din, din);
        chk({name, "_busy"}, busy, 1'b1);
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        logic [1:0] g;
        logic [7:0] d;
        int         s;
        int         prev_s;
        int         lat;
        bit         seen;

        //                valid    data          done ready   start busy din    par   podd  gid
        vecs[0]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0000, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{4'b0001, 32'h000000A5, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[5]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[6]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[7]  = '{4'b1000, 32'h07000000, 1'b0, 4'b1000, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd0};
        vecs[8]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 2'd3};
        vecs[9]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 2'd3};
        vecs[10] = '{4'b0001, 32'h00000003, 1'b0, 4'b0001, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 2'd3};
        vecs[11] = '{4'b0001, 32'h00000003, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 2'd0};
        vecs[12] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 2'd0};
        vecs[13] = '{4'b0110, 32'h00000000, 1'b0, 4'b0010, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 2'd0};
        vecs[14] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1};
        vecs[15] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1};
        vecs[16] = '{4'b1111, 32'h00000000, 1'b0, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1};

`ifdef UART_TX_SCHED_BURST_EN
        exp_rr = '{0, 0, 0, 0, 1};
        exp_b  = '{1, 1, 1, 1, 2, 2, 2, 2};
`else
        exp_rr = '{0, 1, 2, 3, 0};
        exp_b  = '{1, 2, 1, 2, 1, 2, 1, 2};
`endif

        do_reset();
        chk("reset_timeout_err", timeout_err, 1'b0);
        for (int i = 0; i < 17; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            tx_done   = vecs[i].done;
            #1;
            chk($sformatf("v%0d_ready", i),  req_ready,   vecs[i].ready);
            chk($sformatf("v%0d_start", i),  tx_start,    vecs[i].start);
            chk($sformatf("v%0d_busy", i),   busy,        vecs[i].busy);
            chk($sformatf("v%0d_din", i),    tx_din,      vecs[i].din);
            chk($sformatf("v%0d_par", i),    tx_parity,   vecs[i].par);
            chk($sformatf("v%0d_podd", i),   o_tx_parity, vecs[i].podd);
            chk($sformatf("v%0d_gid", i),    grant_id,    vecs[i].gid);
            chk($sformatf("v%0d_tmo", i),    timeout_err, 1'b0);
            tick();
        end

        // Round robin with all four requesters valid; frame length 5.
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h13121110;
        prev_s    = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame(5, $sformatf("rr%0d", i), g, d, s);
            chk($sformatf("rr%0d_gid", i), g, exp_rr[i]);
            chk($sformatf("rr%0d_din", i), d, 8'h10 + exp_rr[i]);
            if (i > 0) chk($sformatf("rr%0d_gap", i), s - prev_s, 7);
            prev_s = s;
        end

        // Timeout: tx_done never arrives.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h00000055;
        wait_start("tmo", seen);
        req_valid = 4'b0000;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (timeout_err === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("tmo_latency", lat, 33);
        chk("tmo_idle_busy", busy, 1'b0);
        tick();
        chk("tmo_single_pulse", timeout_err, 1'b0);

        // tx_done on the expiring cycle wins.
        req_valid = 4'b0001;
        wait_start("tmo_done", seen);
        req_valid = 4'b0000;
        repeat (32) tick();
        tx_done = 1'b1;
        #1;
        chk("tmo_done_busy_before", busy, 1'b1);
        tick();
        tx_done = 1'b0;
        #1;
        chk("tmo_done_no_err", timeout_err, 1'b0);
        chk("tmo_done_idle", busy, 1'b0);
        tick();
        chk("tmo_done_no_err_late", timeout_err, 1'b0);

        // Reset three cycles into WAIT_DONE.
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000DA00;
        wait_start("rst_mid", seen);
        req_valid = 4'b0000;
        repeat (3) tick();
        chk("rst_mid_pre_din", tx_din, 8'hDA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_din", tx_din, 8'h00);
        chk("rst_mid_par", tx_parity, 1'b0);
        chk("rst_mid_podd", o_tx_parity, 1'b0);
        chk("rst_mid_gid", grant_id, 2'd0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_start", tx_start, 1'b0);
        chk("rst_mid_tmo", timeout_err, 1'b0);
        chk("rst_mid_ready_idle", req_ready, 4'b0000);
        req_valid = 4'b0101;
        #1;
        chk("rst_mid_ready", req_ready, 4'b0001);
        tick();
        chk("rst_mid_gid_after", grant_id, 2'd0);

        // Requesters 1 and 2 always valid; burst vs. strict round robin.
        do_reset();
        req_valid = 4'b0110;
        req_data  = 32'h00C3B200;
        for (int i = 0; i < 8; i++) begin
            run_frame(3, $sformatf("burst%0d", i), g, d, s);
            chk($sformatf("burst%0d_gid", i), g, exp_b[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire
